// File: rtl/hazard_forward_unit.sv
// Hazard controller for the 5-stage core: keeps a registered scoreboard of DX/XM/MW
// destinations and drives DX operand forwarding, load-use stalls and mult/div stalls.
module hazard_forward_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int REG_ADDR_W = 5,
   parameter int MD_LATENCY = 32,
   parameter int BYPASS_EN  = 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  fd_valid,
   input  logic [REG_ADDR_W-1:0] fd_rs1,
   input  logic [REG_ADDR_W-1:0] fd_rs2,
   input  logic                  fd_uses_rs1,
   input  logic                  fd_uses_rs2,
   input  logic [REG_ADDR_W-1:0] fd_rd,
   input  logic                  fd_wr,
   input  logic                  fd_is_load,
   input  logic                  fd_is_md,
   input  logic [DATA_WIDTH-1:0] dx_a_in,
   input  logic [DATA_WIDTH-1:0] dx_b_in,
   input  logic [DATA_WIDTH-1:0] xm_o,
   input  logic [DATA_WIDTH-1:0] mw_data,
   output logic [DATA_WIDTH-1:0] dx_a_out,
   output logic [DATA_WIDTH-1:0] dx_b_out,
   output logic [1:0]            fwd_a_sel,
   output logic [1:0]            fwd_b_sel,
   output logic                  stall_fd,
   output logic                  stall_dx,
   output logic                  md_start,
   output logic                  md_busy,
   output logic                  md_done
);

   localparam bit          Bypass = (BYPASS_EN != 0);
   localparam logic [15:0] MdLat  = 16'(MD_LATENCY);

   typedef logic [REG_ADDR_W-1:0] regIdx_t;

   // Later stages keep only the fields the hazard logic consults; the md
   // marker of DX lives in the cycle counter.
   typedef struct packed {
      logic    valid;
      regIdx_t rd;
      logic    wr;
      logic    isLoad;
      regIdx_t rs1;
      regIdx_t rs2;
      logic    use1;
      logic    use2;
   } dxEntry_t;

   typedef struct packed {
      logic    valid;
      regIdx_t rd;
      logic    wr;
      logic    isLoad;
   } xmEntry_t;

   typedef struct packed {
      logic    valid;
      regIdx_t rd;
      logic    wr;
   } mwEntry_t;

   dxEntry_t    dx_q, dx_d;
   xmEntry_t    xm_q, xm_d;
   mwEntry_t    mw_q, mw_d;
   logic [15:0] mdCnt_q, mdCnt_d;

   logic fdHitDx, fdHitXm, fdHitMw;
   logic mdStall, loadUse, rawNoBypass, stallFd;

   function automatic logic hits(logic valid, logic wr, regIdx_t rd, regIdx_t src, logic uses);
      return valid & wr & (rd == src) & (src != '0) & uses;
   endfunction

   always_comb begin
      fdHitDx     = fd_valid & (hits(dx_q.valid, dx_q.wr, dx_q.rd, fd_rs1, fd_uses_rs1) |
                                hits(dx_q.valid, dx_q.wr, dx_q.rd, fd_rs2, fd_uses_rs2));
      fdHitXm     = fd_valid & (hits(xm_q.valid, xm_q.wr, xm_q.rd, fd_rs1, fd_uses_rs1) |
                                hits(xm_q.valid, xm_q.wr, xm_q.rd, fd_rs2, fd_uses_rs2));
      fdHitMw     = fd_valid & (hits(mw_q.valid, mw_q.wr, mw_q.rd, fd_rs1, fd_uses_rs1) |
                                hits(mw_q.valid, mw_q.wr, mw_q.rd, fd_rs2, fd_uses_rs2));
      mdStall     = (mdCnt_q > 16'd1);
      loadUse     = fdHitDx & dx_q.isLoad;
      rawNoBypass = fdHitDx | fdHitXm | fdHitMw;
      stallFd     = mdStall | (Bypass ? loadUse : rawNoBypass);
   end

   assign stall_fd = stallFd;
   assign stall_dx = mdStall;
   assign md_start = (mdCnt_q == MdLat);
   assign md_busy  = (mdCnt_q != 16'd0);
   assign md_done  = (mdCnt_q == 16'd1);

   // XM is the youngest producer so it wins; a load in XM has no data yet.
   always_comb begin
      fwd_a_sel = 2'b00;
      fwd_b_sel = 2'b00;
      if (Bypass && dx_q.valid) begin
         if (hits(xm_q.valid, xm_q.wr, xm_q.rd, dx_q.rs1, dx_q.use1) && !xm_q.isLoad)
            fwd_a_sel = 2'b01;
         else if (hits(mw_q.valid, mw_q.wr, mw_q.rd, dx_q.rs1, dx_q.use1))
            fwd_a_sel = 2'b10;
         if (hits(xm_q.valid, xm_q.wr, xm_q.rd, dx_q.rs2, dx_q.use2) && !xm_q.isLoad)
            fwd_b_sel = 2'b01;
         else if (hits(mw_q.valid, mw_q.wr, mw_q.rd, dx_q.rs2, dx_q.use2))
            fwd_b_sel = 2'b10;
      end
   end

   always_comb begin
      case (fwd_a_sel)
         2'b01:   dx_a_out = xm_o;
         2'b10:   dx_a_out = mw_data;
         default: dx_a_out = dx_a_in;
      endcase
      case (fwd_b_sel)
         2'b01:   dx_b_out = xm_o;
         2'b10:   dx_b_out = mw_data;
         default: dx_b_out = dx_b_in;
      endcase
   end

   // Scoreboard advance: md stall holds DX, hazard stall bubbles DX, else FD moves in.
   always_comb begin
      dx_d        = dx_q;
      xm_d.valid  = dx_q.valid;
      xm_d.rd     = dx_q.rd;
      xm_d.wr     = dx_q.wr;
      xm_d.isLoad = dx_q.isLoad;
      mw_d.valid  = xm_q.valid;
      mw_d.rd     = xm_q.rd;
      mw_d.wr     = xm_q.wr;
      mdCnt_d     = mdCnt_q;
      if (mdStall) begin
         xm_d    = '0;
         mdCnt_d = mdCnt_q - 16'd1;
      end else if (stallFd) begin
         dx_d    = '0;
         mdCnt_d = 16'd0;
      end else begin
         dx_d = '0;
         if (fd_valid) begin
            dx_d.valid  = 1'b1;
            dx_d.rd     = fd_rd;
            dx_d.wr     = fd_wr;
            dx_d.isLoad = fd_is_load;
            dx_d.rs1    = fd_rs1;
            dx_d.rs2    = fd_rs2;
            dx_d.use1   = fd_uses_rs1;
            dx_d.use2   = fd_uses_rs2;
         end
         mdCnt_d = (fd_valid && fd_is_md) ? MdLat : 16'd0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dx_q    <= '0;
         xm_q    <= '0;
         mw_q    <= '0;
         mdCnt_q <= 16'd0;
      end else begin
         dx_q    <= dx_d;
         xm_q    <= xm_d;
         mw_q    <= mw_d;
         mdCnt_q <= mdCnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: dut0 forwards with a 4-cycle mult/div, dut1 stalls
// only with a 1-cycle mult/div; both are compared against a stage-list model.
module tb_hazard_forward_unit;

   typedef struct {
      logic       valid;
      logic [4:0] rd;
      logic       wr;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic       ld;
      logic       md;
   } instr_t;

   typedef struct {
      logic [1:0] sa;
      logic [1:0] sb;
      logic       sfd;
      logic       sdx;
      logic       st;
      logic       bz;
      logic       dn;
   } exp_t;

   typedef struct {
      instr_t fd;
      exp_t   ex;
   } vec_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset;
   logic        fdValid, fdUse1, fdUse2, fdWr, fdLoad, fdMd;
   logic [4:0]  fdRs1, fdRs2, fdRd;
   logic [31:0] aIn, bIn, xmO, mwD;

   logic [1:0]  selA [2];
   logic [1:0]  selB [2];
   logic [31:0] aOut [2];
   logic [31:0] bOut [2];
   logic        sFd  [2];
   logic        sDx  [2];
   logic        mdSt [2];
   logic        mdBz [2];
   logic        mdDn [2];

   int total = 0;
   int bad   = 0;

   instr_t cur;
   instr_t pipe [2][3];
   int     mdLeft [2];
   vec_t   tbl [20];

   hazard_forward_unit #(.DATA_WIDTH(32), .REG_ADDR_W(5), .MD_LATENCY(4), .BYPASS_EN(1)) dut0 (
      .clock(clock), .reset(reset), .fd_valid(fdValid), .fd_rs1(fdRs1), .fd_rs2(fdRs2),
      .fd_uses_rs1(fdUse1), .fd_uses_rs2(fdUse2), .fd_rd(fdRd), .fd_wr(fdWr),
      .fd_is_load(fdLoad), .fd_is_md(fdMd), .dx_a_in(aIn), .dx_b_in(bIn), .xm_o(xmO),
      .mw_data(mwD), .dx_a_out(aOut[0]), .dx_b_out(bOut[0]), .fwd_a_sel(selA[0]),
      .fwd_b_sel(selB[0]), .stall_fd(sFd[0]), .stall_dx(sDx[0]), .md_start(mdSt[0]),
      .md_busy(mdBz[0]), .md_done(mdDn[0]));

   hazard_forward_unit #(.DATA_WIDTH(32), .REG_ADDR_W(5), .MD_LATENCY(1), .BYPASS_EN(0)) dut1 (
      .clock(clock), .reset(reset), .fd_valid(fdValid), .fd_rs1(fdRs1), .fd_rs2(fdRs2),
      .fd_uses_rs1(fdUse1), .fd_uses_rs2(fdUse2), .fd_rd(fdRd), .fd_wr(fdWr),
      .fd_is_load(fdLoad), .fd_is_md(fdMd), .dx_a_in(aIn), .dx_b_in(bIn), .xm_o(xmO),
      .mw_data(mwD), .dx_a_out(aOut[1]), .dx_b_out(bOut[1]), .fwd_a_sel(selA[1]),
      .fwd_b_sel(selB[1]), .stall_fd(sFd[1]), .stall_dx(sDx[1]), .md_start(mdSt[1]),
      .md_busy(mdBz[1]), .md_done(mdDn[1]));

   function automatic instr_t mkI(logic v, logic [4:0] rd, logic wr, logic [4:0] rs1, logic u1,
                                  logic [4:0] rs2, logic u2, logic ld, logic md);
      instr_t i;
      i.valid = v; i.rd = rd; i.wr = wr; i.rs1 = rs1; i.u1 = u1;
      i.rs2 = rs2; i.u2 = u2; i.ld = ld; i.md = md;
      return i;
   endfunction

   function automatic instr_t bubble();
      return mkI(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endfunction

   function automatic exp_t mkE(logic [1:0] sa, logic [1:0] sb, logic sfd, logic sdx,
                                logic st, logic bz, logic dn);
      exp_t e;
      e.sa = sa; e.sb = sb; e.sfd = sfd; e.sdx = sdx; e.st = st; e.bz = bz; e.dn = dn;
      return e;
   endfunction

   function automatic int latOf(int c);
      return (c == 0) ? 4 : 1;
   endfunction

   function automatic bit bypOf(int c);
      return (c == 0);
   endfunction

   function automatic bit writes(instr_t p, logic [4:0] s, logic uses);
      return p.valid && p.wr && (p.rd == s) && (s != 5'd0) && uses;
   endfunction

   function automatic logic [1:0] pickSrc(int c, logic [4:0] s, logic uses);
      if (writes(pipe[c][1], s, uses) && !pipe[c][1].ld) return 2'b01;
      if (writes(pipe[c][2], s, uses)) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [31:0] pickData(logic [1:0] sel, logic [31:0] lat);
      return (sel == 2'b01) ? xmO : (sel == 2'b10) ? mwD : lat;
   endfunction

   function automatic exp_t predict(int c);
      exp_t e;
      bit   anyRaw, loadHit, hit;
      e = mkE(0, 0, 0, 0, 0, 0, 0);
      if (bypOf(c) && pipe[c][0].valid) begin
         e.sa = pickSrc(c, pipe[c][0].rs1, pipe[c][0].u1);
         e.sb = pickSrc(c, pipe[c][0].rs2, pipe[c][0].u2);
      end
      anyRaw  = 0;
      loadHit = 0;
      for (int k = 0; k < 3; k++) begin
         hit = cur.valid && (writes(pipe[c][k], cur.rs1, cur.u1) || writes(pipe[c][k], cur.rs2, cur.u2));
         if (hit) anyRaw = 1;
         if (hit && k == 0 && pipe[c][0].ld) loadHit = 1;
      end
      e.sdx = (mdLeft[c] > 1);
      e.sfd = e.sdx || (bypOf(c) ? loadHit : anyRaw);
      e.st  = (mdLeft[c] == latOf(c));
      e.bz  = (mdLeft[c] != 0);
      e.dn  = (mdLeft[c] == 1);
      return e;
   endfunction

   task automatic modelReset();
      for (int c = 0; c < 2; c++) begin
         for (int k = 0; k < 3; k++) pipe[c][k] = bubble();
         mdLeft[c] = 0;
      end
   endtask

   task automatic modelEdge();
      exp_t e;
      for (int c = 0; c < 2; c++) begin
         e = predict(c);
         pipe[c][2] = pipe[c][1];
         if (e.sdx) begin
            pipe[c][1] = bubble();
            mdLeft[c]  = mdLeft[c] - 1;
         end else begin
            pipe[c][1] = pipe[c][0];
            if (e.sfd || !cur.valid) begin
               pipe[c][0] = bubble();
               mdLeft[c]  = 0;
            end else begin
               pipe[c][0] = cur;
               mdLeft[c]  = cur.md ? latOf(c) : 0;
            end
         end
      end
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, want);
      end
   endtask

   task automatic applyStimulus(instr_t i, logic [31:0] a, logic [31:0] b,
                                logic [31:0] x, logic [31:0] m);
      @(negedge clock);
      cur = i;
      fdValid = i.valid; fdRd = i.rd; fdWr = i.wr; fdRs1 = i.rs1; fdUse1 = i.u1;
      fdRs2 = i.rs2; fdUse2 = i.u2; fdLoad = i.ld; fdMd = i.md;
      aIn = a; bIn = b; xmO = x; mwD = m;
      #1;
   endtask

   task automatic checkOutput(string tag);
      exp_t e;
      for (int c = 0; c < 2; c++) begin
         e = predict(c);
         chk($sformatf("%s dut%0d selA", tag, c), 32'(selA[c]), 32'(e.sa));
         chk($sformatf("%s dut%0d selB", tag, c), 32'(selB[c]), 32'(e.sb));
         chk($sformatf("%s dut%0d aOut", tag, c), aOut[c], pickData(e.sa, aIn));
         chk($sformatf("%s dut%0d bOut", tag, c), bOut[c], pickData(e.sb, bIn));
         chk($sformatf("%s dut%0d stallFd", tag, c), 32'(sFd[c]), 32'(e.sfd));
         chk($sformatf("%s dut%0d stallDx", tag, c), 32'(sDx[c]), 32'(e.sdx));
         chk($sformatf("%s dut%0d mdStart", tag, c), 32'(mdSt[c]), 32'(e.st));
         chk($sformatf("%s dut%0d mdBusy", tag, c), 32'(mdBz[c]), 32'(e.bz));
         chk($sformatf("%s dut%0d mdDone", tag, c), 32'(mdDn[c]), 32'(e.dn));
      end
   endtask

   task automatic checkRow(int r, exp_t e);
      chk($sformatf("row%0d selA", r), 32'(selA[0]), 32'(e.sa));
      chk($sformatf("row%0d selB", r), 32'(selB[0]), 32'(e.sb));
      chk($sformatf("row%0d aOut", r), aOut[0], pickData(e.sa, aIn));
      chk($sformatf("row%0d bOut", r), bOut[0], pickData(e.sb, bIn));
      chk($sformatf("row%0d stallFd", r), 32'(sFd[0]), 32'(e.sfd));
      chk($sformatf("row%0d stallDx", r), 32'(sDx[0]), 32'(e.sdx));
      chk($sformatf("row%0d mdStart", r), 32'(mdSt[0]), 32'(e.st));
      chk($sformatf("row%0d mdBusy", r), 32'(mdBz[0]), 32'(e.bz));
      chk($sformatf("row%0d mdDone", r), 32'(mdDn[0]), 32'(e.dn));
   endtask

   task automatic clockEdge();
      @(posedge clock);
      if (!reset) modelEdge();
   endtask

   task automatic doReset();
      @(negedge clock);
      reset = 1'b1;
      modelReset();
      #1;
      checkOutput("reset");
      reset = 1'b0;
      clockEdge();
   endtask

   task automatic randomInstr(output instr_t i);
      int kind;
      kind = $urandom_range(0, 9);
      i = mkI($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), kind < 2, kind == 2);
      if (!i.valid) i = bubble();
   endtask

   initial begin
      instr_t nop, addR3, sub, useA, prodA, prodB, useB, lw, addL, mul, addM, reader, ri;

      nop    = bubble();
      addR3  = mkI(1, 3, 1, 1, 1, 2, 1, 0, 0);
      sub    = mkI(1, 6, 1, 3, 1, 4, 1, 0, 0);
      useA   = mkI(1, 8, 1, 3, 1, 0, 1, 0, 0);
      prodA  = mkI(1, 3, 1, 1, 1, 2, 1, 0, 0);
      prodB  = mkI(1, 3, 1, 1, 1, 2, 1, 0, 0);
      useB   = mkI(1, 9, 1, 0, 1, 3, 1, 0, 0);
      lw     = mkI(1, 5, 1, 1, 1, 0, 0, 1, 0);
      addL   = mkI(1, 10, 1, 2, 1, 5, 1, 0, 0);
      mul    = mkI(1, 7, 1, 1, 1, 2, 1, 0, 1);
      addM   = mkI(1, 11, 1, 7, 1, 1, 1, 0, 0);
      reader = mkI(1, 12, 1, 3, 1, 0, 0, 0, 0);

      // Hand-derived expectations for dut0 (forwarding, 4-cycle mult/div).
      tbl[0]  = '{fd: addR3, ex: mkE(0, 0, 0, 0, 0, 0, 0)};
      tbl[1]  = '{fd: sub,   ex: mkE(0, 0, 0, 0, 0, 0, 0)};
      tbl[2]  = '{fd: nop,   ex: mkE(1, 0, 0, 0, 0, 0, 0)};
      tbl[3]  = '{fd: addR3, ex: mkE(0, 0, 0, 0, 0, 0, 0)};
      tbl[4]  = '{fd: nop,   ex: mkE(0, 0, 0, 0, 0, 0, 0)};
      tbl[5]  = '{fd: useA,  ex: mkE(0, 0, 0, 0, 0, 0, 0)};
      tbl[6]  = '{fd: prodA, ex: mkE(2, 0, 0, 0, 0, 0, 0)};
      tbl[7]  = '{fd: prodB, ex: mkE(0, 0, 0, 0, 0, 0, 0)};
      tbl[8]  = '{fd: useB,  ex: mkE(0, 0, 0, 0, 0, 0, 0)};
      tbl[9]  = '{fd: nop,   ex: mkE(0, 1, 0, 0, 0, 0, 0)};
      tbl[10] = '{fd: lw,    ex: mkE(0, 0, 0, 0, 0, 0, 0)};
      tbl[11] = '{fd: addL,  ex: mkE(0, 0, 1, 0, 0, 0, 0)};
      tbl[12] = '{fd: addL,  ex: mkE(0, 0, 0, 0, 0, 0, 0)};
      tbl[13] = '{fd: nop,   ex: mkE(0, 2, 0, 0, 0, 0, 0)};
      tbl[14] = '{fd: mul,   ex: mkE(0, 0, 0, 0, 0, 0, 0)};
      tbl[15] = '{fd: addM,  ex: mkE(0, 0, 1, 1, 1, 1, 0)};
      tbl[16] = '{fd: addM,  ex: mkE(0, 0, 1, 1, 0, 1, 0)};
      tbl[17] = '{fd: addM,  ex: mkE(0, 0, 1, 1, 0, 1, 0)};
      tbl[18] = '{fd: addM,  ex: mkE(0, 0, 0, 0, 0, 1, 1)};
      tbl[19] = '{fd: nop,   ex: mkE(1, 0, 0, 0, 0, 0, 0)};

      reset = 1'b1;
      modelReset();
      applyStimulus(nop, 32'h1234_5678, 32'h9ABC_DEF0, 32'hAA, 32'h55);
      checkOutput("reset");
      reset = 1'b0;
      clockEdge();

      $display("[TB] table vectors");
      for (int r = 0; r < 20; r++) begin
         applyStimulus(tbl[r].fd, 32'h1000_0000 | 32'(r), 32'h2000_0000 | 32'(r), 32'h0000_00AA, 32'h0000_0055);
         checkOutput($sformatf("tbl%0d", r));
         checkRow(r, tbl[r].ex);
         clockEdge();
      end

      $display("[TB] stall-only RAW on dut1");
      doReset();
      applyStimulus(addR3, $urandom, $urandom, $urandom, $urandom);
      checkOutput("nobyp0");
      chk("nobyp c0 stallFd", 32'(sFd[1]), 32'd0);
      clockEdge();
      for (int k = 0; k < 4; k++) begin
         applyStimulus(reader, $urandom, $urandom, $urandom, $urandom);
         checkOutput($sformatf("nobyp%0d", k + 1));
         chk($sformatf("nobyp c%0d stallFd", k + 1), 32'(sFd[1]), (k < 3) ? 32'd1 : 32'd0);
         chk($sformatf("nobyp c%0d selA", k + 1), 32'(selA[1]), 32'd0);
         clockEdge();
      end
      applyStimulus(nop, $urandom, $urandom, $urandom, $urandom);
      checkOutput("nobyp5");
      chk("nobyp consumer selA", 32'(selA[1]), 32'd0);
      chk("nobyp consumer aOut", aOut[1], aIn);
      clockEdge();

      $display("[TB] single-cycle mult/div on dut1");
      doReset();
      applyStimulus(mul, $urandom, $urandom, $urandom, $urandom);
      clockEdge();
      applyStimulus(nop, $urandom, $urandom, $urandom, $urandom);
      checkOutput("md1");
      chk("md1 start", 32'(mdSt[1]), 32'd1);
      chk("md1 busy", 32'(mdBz[1]), 32'd1);
      chk("md1 done", 32'(mdDn[1]), 32'd1);
      chk("md1 stallDx", 32'(sDx[1]), 32'd0);
      clockEdge();
      applyStimulus(nop, $urandom, $urandom, $urandom, $urandom);
      chk("md1 busy after", 32'(mdBz[1]), 32'd0);
      clockEdge();

      $display("[TB] reset during mult/div on dut0");
      doReset();
      applyStimulus(mul, $urandom, $urandom, $urandom, $urandom);
      clockEdge();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(addM, $urandom, $urandom, $urandom, $urandom);
         checkOutput($sformatf("mdrst%0d", k));
         if (k < 2) clockEdge();
      end
      chk("mdrst pre stallDx", 32'(sDx[0]), 32'd1);
      reset = 1'b1;
      modelReset();
      #1;
      chk("mdrst busy", 32'(mdBz[0]), 32'd0);
      chk("mdrst stallFd", 32'(sFd[0]), 32'd0);
      chk("mdrst stallDx", 32'(sDx[0]), 32'd0);
      checkOutput("mdrst async");
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("mdrst post selA", 32'(selA[0]), 32'd0);
      chk("mdrst post selB", 32'(selB[0]), 32'd0);
      checkOutput("mdrst post");
      clockEdge();

      $display("[TB] random stimulus");
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 63) == 0) doReset();
         randomInstr(ri);
         applyStimulus(ri, $urandom, $urandom, $urandom, $urandom);
         checkOutput($sformatf("rnd%0d", n));
         clockEdge();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
